io_boot_ctrl: RTL and testbench
===============================

# io_boot_ctrl

Memory-mapped I/O and boot-load controller that sits between the multi-cycle RV32I core (controller + datapath) and its word-addressed program/data RAM. It replaces the single-outport, always-on flash path with a handshaked loader, a run/hold gate for the core, and parametrised banks of input and output ports. At reset it holds the core, accepts an image over the flash interface, then releases the core and arbitrates its loads/stores between RAM and I/O registers.

## Interface
- WIDTH, 32, data/address width
- RAM_DEPTH, 256, RAM size in words (power of two)
- NUM_OUTPORTS, 4, writable output registers (1..16)
- NUM_INPORTS, 2, readable input ports (1..16)
- IO_BASE, 32'h0000_FF00, base byte address of the I/O window
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- flash_valid  in  1  loader beat valid
- flash_ready  out  1  loader beat accepted when valid & ready
- flash_addr  in  WIDTH  byte address of beat
- flash_data  in  WIDTH  word to store
- flash_last  in  1  final beat of image
- core_run  out  1  core enable; 0 holds core
- load_err  out  1  sticky: a beat was dropped
- load_count  out  $clog2(RAM_DEPTH+1)  words written by loader, saturating
- mem_addr  in  WIDTH  core byte address
- mem_wdata  in  WIDTH  core store data
- mem_wren  in  1  core store strobe
- mem_rden  in  1  core load strobe
- mem_rdata  out  WIDTH  load data, one cycle after mem_rden
- ram_addr  out  $clog2(RAM_DEPTH)  RAM word address
- ram_wdata  out  WIDTH  RAM write data
- ram_wren  out  1  RAM write enable
- ram_rdata  in  WIDTH  RAM read data, one cycle after ram_addr
- inports  in  NUM_INPORTS*WIDTH  input port bank, port j at bits [j*WIDTH +: WIDTH]
- outports  out  NUM_OUTPORTS*WIDTH  output register bank, same packing

## Operation
- States: LOAD, RUN. Reset (rst=0 at a clk edge) enters LOAD from any state.
- Reset values: state=LOAD, flash_ready=1, core_run=0, load_err=0, load_count=0, outports=0, mem_rdata=0.
- LOAD: flash_ready=1. Accepted beat with flash_addr[1:0]==0 and flash_addr < RAM_DEPTH*4: ram_wren=1, ram_addr=flash_addr[2+:$clog2(RAM_DEPTH)], ram_wdata=flash_data, load_count+1 (saturates at RAM_DEPTH). Misaligned or out-of-range beat: no write, load_err set. An accepted beat with flash_last=1 (written or dropped) moves to RUN. Core strobes ignored in LOAD.
- RUN: flash_ready=0, core_run=1; flash inputs ignored. Only reset returns to LOAD.
- Decode (RUN): mem_addr < IO_BASE → RAM, word index = mem_addr[2+:$clog2(RAM_DEPTH)]. Outport i at IO_BASE+4*i (read/write). Inport j at IO_BASE+0x40+4*j (read-only). Any other I/O-window address: store ignored, load returns 0.
- Stores: RAM store drives ram_wren for that cycle; outport store updates outport i on the next edge.
- Loads: source (RAM/outport/inport/zero) registered with mem_rden; mem_rdata valid exactly one cycle later for every source. Outport load in the same cycle as a store to it returns the pre-store value. mem_rden and mem_wren together: both performed.

## Timing
- Loader: one beat per cycle max; write issued in the acceptance cycle; core_run rises the cycle after the flash_last beat.
- Load latency 1 cycle, uniform; outport store visible on outports 1 cycle after strobe.
- Inport sample is combinational into the registered read path (0 extra cycles) without the sync option.

## Configuration
- IO_BOOT_INSYNC_EN defined: each inport passes through a two-flop synchronizer (reset 0); inport value seen by loads lags the pin by 2 cycles. Undefined: inports sampled directly, no added latency.

## Structure
- Package io_boot_pkg: boot_state_t {BOOT_LOAD, BOOT_RUN}; rd_src_t {SRC_RAM, SRC_OUT, SRC_IN, SRC_ZERO}; IO_OUT_OFFSET=0x00, IO_IN_OFFSET=0x40.
- Sub-module io_sync2 (parametrised-width two-flop synchronizer), instantiated only under IO_BOOT_INSYNC_EN.

## Test plan
- Load 3 beats addr 0x0/0x4/0x8, last on third → RAM words 0..2 written, load_count=3, core_run=1 next cycle, flash_ready=0.
- Beats at 0x2 and 0x400 (RAM_DEPTH=256), then last at 0xC → neither written, load_err=1, load_count=1.
- RUN: store 0xDEADBEEF to 0xFF04 → outports[63:32]=0xDEADBEEF next cycle; load 0xFF04 → mem_rdata=0xDEADBEEF one cycle later.
- RUN: inports={32'h5, 32'hA}; load 0xFF44 → 0x5, load 0xFF40 → 0xA (extra 2-cycle lag with IO_BOOT_INSYNC_EN); load 0xFF80 → 0.
- Same-cycle load+store to 0xFF00 (old 0x1, new 0x2) → mem_rdata=0x1, outports[31:0]=0x2.
- rst=0 during RUN with outports nonzero → next edge: LOAD, core_run=0, outports=0, load_count=0, load_err=0.

Source files
------------

// File: rtl/io_boot_pkg.sv
// Shared types and I/O window offsets for the boot/I-O controller.
package io_boot_pkg;

  typedef enum logic [0:0] {
    BOOT_LOAD = 1'b0,
    BOOT_RUN  = 1'b1
  } boot_state_t;

  typedef enum logic [1:0] {
    SRC_RAM  = 2'd0,
    SRC_OUT  = 2'd1,
    SRC_IN   = 2'd2,
    SRC_ZERO = 2'd3
  } rd_src_t;

  localparam logic [31:0] IO_OUT_OFFSET = 32'h0000_0000;
  localparam logic [31:0] IO_IN_OFFSET  = 32'h0000_0040;

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer, parametrised width, synchronous active-low reset to zero.
module io_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture of the asynchronous input bank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/io_boot_ctrl.sv
// Boot loader + memory-mapped I/O arbiter for the RV32I core.
// Optional IO_BOOT_INSYNC_EN: route inports through io_sync2 (2-cycle lag).
module io_boot_ctrl
  import io_boot_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               RAM_DEPTH    = 256,
  parameter int               NUM_OUTPORTS = 4,
  parameter int               NUM_INPORTS  = 2,
  parameter logic [WIDTH-1:0] IO_BASE      = WIDTH'(32'h0000_FF00)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flash_valid,
  output logic                              flash_ready,
  input  logic [WIDTH-1:0]                  flash_addr,
  input  logic [WIDTH-1:0]                  flash_data,
  input  logic                              flash_last,
  output logic                              core_run,
  output logic                              load_err,
  output logic [$clog2(RAM_DEPTH+1)-1:0]    load_count,
  input  logic [WIDTH-1:0]                  mem_addr,
  input  logic [WIDTH-1:0]                  mem_wdata,
  input  logic                              mem_wren,
  input  logic                              mem_rden,
  output logic [WIDTH-1:0]                  mem_rdata,
  output logic [$clog2(RAM_DEPTH)-1:0]      ram_addr,
  output logic [WIDTH-1:0]                  ram_wdata,
  output logic                              ram_wren,
  input  logic [WIDTH-1:0]                  ram_rdata,
  input  logic [NUM_INPORTS*WIDTH-1:0]      inports,
  output logic [NUM_OUTPORTS*WIDTH-1:0]     outports
);

  localparam int               AW        = $clog2(RAM_DEPTH);
  localparam int               CW        = $clog2(RAM_DEPTH + 1);
  localparam logic [WIDTH-1:0] RAM_BYTES = WIDTH'(RAM_DEPTH * 4);
  localparam logic [WIDTH-1:0] OUT_LO    = WIDTH'(IO_OUT_OFFSET);
  localparam logic [WIDTH-1:0] OUT_END   = WIDTH'(IO_OUT_OFFSET) + WIDTH'(4 * NUM_OUTPORTS);
  localparam logic [WIDTH-1:0] IN_LO     = WIDTH'(IO_IN_OFFSET);
  localparam logic [WIDTH-1:0] IN_END    = WIDTH'(IO_IN_OFFSET) + WIDTH'(4 * NUM_INPORTS);

  boot_state_t      state_r;
  logic             flash_ready_r;
  logic             core_run_r;
  logic             load_err_r;
  logic [CW-1:0]    load_count_r;
  logic [WIDTH-1:0] out_q_r [NUM_OUTPORTS];
  rd_src_t          rd_src_r;
  logic [WIDTH-1:0] rd_data_r;

  logic [NUM_INPORTS*WIDTH-1:0] in_pins_s;
  logic             run_s;
  logic             beat_acc_s;
  logic             beat_ok_s;
  logic             is_ram_s;
  logic [WIDTH-1:0] io_off_s;
  logic             out_hit_s;
  logic             in_hit_s;
  logic [3:0]       out_idx_s;
  logic [3:0]       in_idx_s;
  rd_src_t          src_s;
  logic [WIDTH-1:0] out_rd_s;
  logic [WIDTH-1:0] in_rd_s;

`ifdef IO_BOOT_INSYNC_EN
  io_sync2 #(.WIDTH(NUM_INPORTS * WIDTH)) u_in_sync (
    .clk (clk),
    .rst (rst),
    .d   (inports),
    .q   (in_pins_s)
  );
`else
  assign in_pins_s = inports;
`endif

  // Loader acceptance and core address decode.
  always_comb begin
    run_s      = (state_r == BOOT_RUN);
    beat_acc_s = (state_r == BOOT_LOAD) && flash_valid && flash_ready_r;
    beat_ok_s  = (flash_addr[1:0] == 2'b00) && (flash_addr < RAM_BYTES);
    is_ram_s   = (mem_addr < IO_BASE);
    io_off_s   = mem_addr - IO_BASE;
    // OUT_LO is the window base, so only the upper bound needs testing.
    out_hit_s  = !is_ram_s && (io_off_s[1:0] == 2'b00) && (io_off_s < OUT_END);
    in_hit_s   = !is_ram_s && (io_off_s[1:0] == 2'b00) &&
                 (io_off_s >= IN_LO) && (io_off_s < IN_END);
    out_idx_s  = 4'((io_off_s - OUT_LO) >> 2);
    in_idx_s   = 4'((io_off_s - IN_LO) >> 2);
    if (is_ram_s) begin
      src_s = SRC_RAM;
    end else if (out_hit_s) begin
      src_s = SRC_OUT;
    end else if (in_hit_s) begin
      src_s = SRC_IN;
    end else begin
      src_s = SRC_ZERO;
    end
  end

  // Read-value selection from the port banks.
  always_comb begin
    out_rd_s = '0;
    in_rd_s  = '0;
    for (int i = 0; i < NUM_OUTPORTS; i++) begin
      out_rd_s = (out_idx_s == 4'(i)) ? out_q_r[i] : out_rd_s;
    end
    for (int j = 0; j < NUM_INPORTS; j++) begin
      in_rd_s = (in_idx_s == 4'(j)) ? in_pins_s[j*WIDTH +: WIDTH] : in_rd_s;
    end
  end

  // RAM port owner: loader in LOAD, core in RUN.
  always_comb begin
    if (run_s) begin
      ram_addr  = mem_addr[2 +: AW];
      ram_wdata = mem_wdata;
      ram_wren  = mem_wren && is_ram_s;
    end else begin
      ram_addr  = flash_addr[2 +: AW];
      ram_wdata = flash_data;
      ram_wren  = beat_acc_s && beat_ok_s;
    end
  end

  // Boot FSM with loader bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= BOOT_LOAD;
      flash_ready_r <= 1'b1;
      core_run_r    <= 1'b0;
      load_err_r    <= 1'b0;
      load_count_r  <= '0;
    end else begin
      case (state_r)
        BOOT_LOAD: begin
          if (beat_acc_s) begin
            if (beat_ok_s) begin
              if (load_count_r != CW'(RAM_DEPTH)) begin
                load_count_r <= load_count_r + CW'(1);
              end
            end else begin
              load_err_r <= 1'b1;
            end
            if (flash_last) begin
              state_r       <= BOOT_RUN;
              flash_ready_r <= 1'b0;
              core_run_r    <= 1'b1;
            end
          end
        end
        BOOT_RUN: begin
          flash_ready_r <= 1'b0;
          core_run_r    <= 1'b1;
        end
        default: begin
          state_r       <= BOOT_LOAD;
          flash_ready_r <= 1'b1;
          core_run_r    <= 1'b0;
        end
      endcase
    end
  end

  // Output-port stores and the registered load path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_OUTPORTS; i++) begin
        out_q_r[i] <= '0;
      end
      rd_src_r  <= SRC_ZERO;
      rd_data_r <= '0;
    end else begin
      for (int i = 0; i < NUM_OUTPORTS; i++) begin
        if (run_s && mem_wren && out_hit_s && (out_idx_s == 4'(i))) begin
          out_q_r[i] <= mem_wdata;
        end
      end
      // Captures pre-store outport value when load and store coincide.
      if (run_s && mem_rden) begin
        rd_src_r <= src_s;
        case (src_s)
          SRC_OUT: rd_data_r <= out_rd_s;
          SRC_IN:  rd_data_r <= in_rd_s;
          default: rd_data_r <= '0;
        endcase
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_OUTPORTS; g++) begin : g_pack
      assign outports[g*WIDTH +: WIDTH] = out_q_r[g];
    end
  endgenerate

  assign flash_ready = flash_ready_r;
  assign core_run    = core_run_r;
  assign load_err    = load_err_r;
  assign load_count  = load_count_r;
  // RAM data arrives one cycle after address, aligned with the registered source.
  assign mem_rdata   = (rd_src_r == SRC_RAM) ? ram_rdata : rd_data_r;

endmodule

// File: tb/tb_io_boot_ctrl.sv
// Directed self-checking bench for io_boot_ctrl with a behavioural RAM.
module tb_io_boot_ctrl;

  localparam int WIDTH = 32;

  logic              clk;
  logic              rst;
  logic              flash_valid;
  logic              flash_ready;
  logic [31:0]       flash_addr;
  logic [31:0]       flash_data;
  logic              flash_last;
  logic              core_run;
  logic              load_err;
  logic [8:0]        load_count;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_wren;
  logic              mem_rden;
  logic [31:0]       mem_rdata;
  logic [7:0]        ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_wren;
  logic [31:0]       ram_rdata;
  logic [63:0]       inports;
  logic [127:0]      outports;

  int checks = 0;
  int errors = 0;
  logic [31:0] tb_mem [256];

  io_boot_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .flash_valid (flash_valid),
    .flash_ready (flash_ready),
    .flash_addr  (flash_addr),
    .flash_data  (flash_data),
    .flash_last  (flash_last),
    .core_run    (core_run),
    .load_err    (load_err),
    .load_count  (load_count),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wren    (mem_wren),
    .mem_rden    (mem_rden),
    .mem_rdata   (mem_rdata),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_wren    (ram_wren),
    .ram_rdata   (ram_rdata),
    .inports     (inports),
    .outports    (outports)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (ram_wren) tb_mem[ram_addr] <= ram_wdata;
    ram_rdata <= tb_mem[ram_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    flash_valid = 1'b0;
    flash_last  = 1'b0;
    mem_wren    = 1'b0;
    mem_rden    = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle();
    tick();
    tick();
    checks++; if (flash_ready !== 1'b1) begin errors++; $display("FAIL rst_flash_ready got %0h exp 1", flash_ready); end
    checks++; if (core_run !== 1'b0) begin errors++; $display("FAIL rst_core_run got %0h exp 0", core_run); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL rst_load_err got %0h exp 0", load_err); end
    checks++; if (load_count !== 9'd0) begin errors++; $display("FAIL rst_load_count got %0d exp 0", load_count); end
    checks++; if (outports !== 128'h0) begin errors++; $display("FAIL rst_outports got %0h exp 0", outports); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_mem_rdata got %0h exp 0", mem_rdata); end
    rst = 1'b1;
  endtask

  task automatic test_load;
    logic [31:0] data_tab [3];
    data_tab = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    for (int k = 0; k < 3; k++) begin
      flash_valid = 1'b1;
      flash_addr  = 32'(4 * k);
      flash_data  = data_tab[k];
      flash_last  = (k == 2);
      #1;
      checks++; if (ram_wren !== 1'b1 || ram_addr !== 8'(k)) begin errors++; $display("FAIL load_wr%0d got wren=%0h addr=%0h exp 1/%0h", k, ram_wren, ram_addr, k); end
      checks++; if (core_run !== 1'b0) begin errors++; $display("FAIL load_hold%0d got core_run=%0h exp 0", k, core_run); end
      tick();
    end
    idle();
    checks++; if (core_run !== 1'b1) begin errors++; $display("FAIL load_core_run got %0h exp 1", core_run); end
    checks++; if (flash_ready !== 1'b0) begin errors++; $display("FAIL load_flash_ready got %0h exp 0", flash_ready); end
    checks++; if (load_count !== 9'd3) begin errors++; $display("FAIL load_count got %0d exp 3", load_count); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (tb_mem[k] !== data_tab[k]) begin errors++; $display("FAIL load_ram%0d got %0h exp %0h", k, tb_mem[k], data_tab[k]); end
    end
  endtask

  task automatic test_load_err;
    logic [31:0] addr_tab [3];
    addr_tab = '{32'h2, 32'h400, 32'hC};
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      flash_valid = 1'b1;
      flash_addr  = addr_tab[k];
      flash_data  = (k == 2) ? 32'h4444_4444 : 32'hAAAA_0000 + 32'(k);
      flash_last  = (k == 2);
      #1;
      checks++; if (ram_wren !== (k == 2)) begin errors++; $display("FAIL err_wren%0d got %0h exp %0h", k, ram_wren, (k == 2)); end
      tick();
    end
    idle();
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL err_load_err got %0h exp 1", load_err); end
    checks++; if (load_count !== 9'd1) begin errors++; $display("FAIL err_load_count got %0d exp 1", load_count); end
    checks++; if (tb_mem[3] !== 32'h4444_4444) begin errors++; $display("FAIL err_ram3 got %0h exp 44444444", tb_mem[3]); end
    checks++; if (tb_mem[0] !== 32'h1111_1111) begin errors++; $display("FAIL err_ram0_kept got %0h exp 11111111", tb_mem[0]); end
    checks++; if (core_run !== 1'b1) begin errors++; $display("FAIL err_core_run got %0h exp 1", core_run); end
  endtask

  task automatic test_ram_access;
    flash_valid = 1'b1;
    flash_addr  = 32'h20;
    flash_data  = 32'h0000_0099;
    flash_last  = 1'b1;
    mem_addr    = 32'h10;
    mem_wdata   = 32'h5566_7788;
    mem_wren    = 1'b1;
    #1;
    checks++; if (ram_wren !== 1'b1 || ram_addr !== 8'd4) begin errors++; $display("FAIL run_ram_wr got wren=%0h addr=%0h exp 1/4", ram_wren, ram_addr); end
    tick();
    idle();
    checks++; if (tb_mem[4] !== 32'h5566_7788) begin errors++; $display("FAIL run_ram_store got %0h exp 55667788", tb_mem[4]); end
    checks++; if (tb_mem[8] !== 32'h0 || load_count !== 9'd1) begin errors++; $display("FAIL run_flash_ignored got mem8=%0h cnt=%0d exp 0/1", tb_mem[8], load_count); end
    mem_addr = 32'hC;
    mem_rden = 1'b1;
    tick();
    mem_rden = 1'b0;
    checks++; if (mem_rdata !== 32'h4444_4444) begin errors++; $display("FAIL run_ram_load got %0h exp 44444444", mem_rdata); end
  endtask

  task automatic test_outport;
    mem_addr  = 32'hFF04;
    mem_wdata = 32'hDEAD_BEEF;
    mem_wren  = 1'b1;
    #1;
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL out_no_ram_wr got %0h exp 0", ram_wren); end
    tick();
    mem_wren = 1'b0;
    checks++; if (outports[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL out_store got %0h exp deadbeef", outports[63:32]); end
    mem_rden = 1'b1;
    tick();
    mem_rden = 1'b0;
    checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL out_load got %0h exp deadbeef", mem_rdata); end
  endtask

  task automatic test_inport;
    logic [31:0] a_tab [3];
    logic [31:0] e_tab [3];
    a_tab = '{32'hFF44, 32'hFF40, 32'hFF80};
    e_tab = '{32'h5, 32'hA, 32'h0};
    inports = {32'h5, 32'hA};
    tick();
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_addr = a_tab[k];
      mem_rden = 1'b1;
      tick();
      mem_rden = 1'b0;
      checks++; if (mem_rdata !== e_tab[k]) begin errors++; $display("FAIL in_load%0d got %0h exp %0h", k, mem_rdata, e_tab[k]); end
    end
    mem_addr  = 32'hFF80;
    mem_wdata = 32'hFFFF_FFFF;
    mem_wren  = 1'b1;
    tick();
    mem_wren = 1'b0;
    checks++; if (outports !== {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0}) begin errors++; $display("FAIL in_bad_store got %0h exp 00000000_00000000_deadbeef_00000000", outports); end
  endtask

  task automatic test_same_cycle;
    mem_addr  = 32'hFF00;
    mem_wdata = 32'h1;
    mem_wren  = 1'b1;
    tick();
    mem_wdata = 32'h2;
    mem_rden  = 1'b1;
    tick();
    idle();
    checks++; if (mem_rdata !== 32'h1) begin errors++; $display("FAIL same_load_old got %0h exp 1", mem_rdata); end
    checks++; if (outports[31:0] !== 32'h2) begin errors++; $display("FAIL same_store_new got %0h exp 2", outports[31:0]); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a_tab [3];
    logic [31:0] e_tab [3];
    a_tab = '{32'hFF00, 32'hFF04, 32'hC};
    e_tab = '{32'h2, 32'hDEAD_BEEF, 32'h4444_4444};
    mem_rden = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_addr = a_tab[k];
      tick();
      checks++; if (mem_rdata !== e_tab[k]) begin errors++; $display("FAIL b2b_load%0d got %0h exp %0h", k, mem_rdata, e_tab[k]); end
    end
    mem_rden = 1'b0;
  endtask

  task automatic test_run_reset;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (core_run !== 1'b0 || flash_ready !== 1'b1) begin errors++; $display("FAIL rr_state got run=%0h rdy=%0h exp 0/1", core_run, flash_ready); end
    checks++; if (outports !== 128'h0) begin errors++; $display("FAIL rr_outports got %0h exp 0", outports); end
    checks++; if (load_count !== 9'd0 || load_err !== 1'b0) begin errors++; $display("FAIL rr_load got cnt=%0d err=%0h exp 0/0", load_count, load_err); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rr_mem_rdata got %0h exp 0", mem_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
    flash_addr = 32'h0;
    flash_data = 32'h0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    inports    = 64'h0;
    idle();
    test_reset();
    test_load();
    test_load_err();
    test_ram_access();
    test_outport();
    test_inport();
    test_same_cycle();
    test_back_to_back();
    test_run_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
